// File: rtl/sha256_msg_sched_pkg.sv
// Shared constants for the SHA-256 message-schedule unit.
package sha256_msg_sched_pkg;

  // Rounds per SHA-256 block and depth of the message-schedule sliding window.
  localparam int unsigned NumRounds = 64;
  localparam int unsigned WinDepth  = 16;

  // Round-counter values: t == TIdle means the schedule is finished / idle,
  // t < TExpand means message words are passed straight through from the input.
  localparam logic [6:0] TIdle   = 7'd64;
  localparam logic [6:0] TExpand = 7'd16;

endpackage

// File: rtl/sha256_k_rom.sv
// FIPS 180-4 SHA-256 round constants K_0..K_63 as a combinational ROM.
module sha256_k_rom (
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  localparam logic [31:0] KTable [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k = KTable[idx];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: streams (W_t, K_t) for t = 0..63 into the round unit,
// cycle-aligned with it through a shared start latency (configDelay).
module sha256_msg_sched
  import sha256_msg_sched_pkg::*;
#(
  parameter int unsigned DELAY_W = 10,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              done,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  input  logic [7:0]        configDelay
);

  // DELAY_W and DATA_W only shape the unit-template signature; the datapath is 32 bits.
  if (DELAY_W == 0 || DATA_W != 32) begin : g_template_params
  end

  logic [7:0]  delay_cnt;
  logic [6:0]  t_cnt;
  logic [31:0] win [WinDepth];
  logic [31:0] w_exp;
  logic [31:0] k_val;
  logic        active;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  sha256_k_rom u_k_rom (
    .idx (t_cnt[5:0]),
    .k   (k_val)
  );

  assign active = (delay_cnt == 8'd0) && (t_cnt < TIdle);
  assign done   = (delay_cnt == 8'd0) && (t_cnt == TIdle);

  // Output word selection: pass message words through, then expand from the window.
  always_comb begin
    w_exp = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    out0  = '0;
    out1  = '0;
    if (active) begin
      out1 = k_val;
      out0 = (t_cnt < TExpand) ? in0 : w_exp;
    end
  end

  // Delay countdown, round counter and window shift; run restarts from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_cnt <= '0;
      t_cnt     <= TIdle;
      for (int i = 0; i < WinDepth; i++) win[i] <= '0;
    end else if (run) begin
      delay_cnt <= configDelay;
      t_cnt     <= '0;
      for (int i = 0; i < WinDepth; i++) win[i] <= '0;
    end else if (delay_cnt != 8'd0) begin
      delay_cnt <= delay_cnt - 8'd1;
    end else if (t_cnt < TIdle) begin
      for (int i = 0; i < WinDepth - 1; i++) win[i] <= win[i+1];
      win[WinDepth-1] <= out0;
      t_cnt           <= t_cnt + 7'd1;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: table of schedules with hand-derived
// W16/W17, a per-round scoreboard from an array-based reference schedule, and
// corner sequences (reset mid-run, restart mid-run, digest through a round model).
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        done;
  logic [31:0] in0;
  logic [31:0] out0;
  logic [31:0] out1;
  logic [7:0]  configDelay;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] w;
    logic [31:0] k;
  } sb_t;

  typedef struct {
    logic [7:0]  d;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] m15;
    logic [31:0] exp_w16;
    logic [31:0] exp_w17;
  } vec_t;

  sb_t         sb [$];
  logic [31:0] msg   [16];
  logic [31:0] cap_w [64];
  logic [31:0] cap_k [64];
  vec_t        vecs  [5];

  localparam logic [31:0] KRef [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] HInit [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] AbcDigest [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  sha256_msg_sched #(
    .DELAY_W (10),
    .DATA_W  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .done        (done),
    .in0         (in0),
    .out0        (out0),
    .out1        (out1),
    .configDelay (configDelay)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One full run: pulse run in cycle 0, then check the wait, each round, and idle.
  // Returns early after round abort_at-1 is checked (abort_at = 64 runs to completion).
  task automatic run_schedule(input logic [7:0] d, input int abort_at);
    logic [31:0] wref [64];
    sb_t         e;
    int          r;
    logic        wait_ok;
    for (int i = 0; i < 16; i++) wref[i] = msg[i];
    for (int i = 16; i < 64; i++)
      wref[i] = ssig1(wref[i-2]) + wref[i-7] + ssig0(wref[i-15]) + wref[i-16];
    sb.delete();
    @(posedge clk); #1;
    run         = 1'b1;
    configDelay = d;
    in0         = $urandom;
    for (int i = 0; i < 64; i++) sb.push_back('{w: wref[i], k: KRef[i]});
    wait_ok = 1'b1;
    for (int c = 1; c <= int'(d) + 65; c++) begin
      @(posedge clk); #1;
      run = 1'b0;
      r   = c - int'(d) - 1;
      if (r >= 0 && r < 16) in0 = msg[r];
      else                  in0 = $urandom;
      @(negedge clk);
      if (r < 0) begin
        if (out0 !== 32'd0 || out1 !== 32'd0 || done !== 1'b0) wait_ok = 1'b0;
        if (c == int'(d)) check($sformatf("wait_d%0d", d), 96'(wait_ok), 96'd1);
      end else if (r < 64) begin
        if (sb.size() == 0) begin
          check($sformatf("sb_empty_r%0d", r), 96'(sb.size()), 96'd1);
        end else begin
          e = sb.pop_front();
          check($sformatf("round_d%0d_t%0d", d, r), {31'd0, done, out0, out1},
                {32'd0, e.w, e.k});
        end
        cap_w[r] = out0;
        cap_k[r] = out1;
        if (r == abort_at - 1) return;
      end else begin
        check($sformatf("idle_after_d%0d", d), {31'd0, done, out0, out1},
              {31'd0, 1'b1, 64'd0});
      end
    end
  endtask

  function automatic void load_msg(input vec_t v);
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0]  = v.m0;
    msg[1]  = v.m1;
    msg[15] = v.m15;
  endfunction

  // Run the captured (W, K) stream through a reference compression round model.
  task automatic check_digest();
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [31:0] dig [8];
    a = HInit[0]; b = HInit[1]; c = HInit[2]; d = HInit[3];
    e = HInit[4]; f = HInit[5]; g = HInit[6]; h = HInit[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g))
           + cap_k[t] + cap_w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    dig[0] = a + HInit[0]; dig[1] = b + HInit[1]; dig[2] = c + HInit[2];
    dig[3] = d + HInit[3]; dig[4] = e + HInit[4]; dig[5] = f + HInit[5];
    dig[6] = g + HInit[6]; dig[7] = h + HInit[7];
    for (int i = 0; i < 8; i++) check($sformatf("digest_%0d", i), 96'(dig[i]), 96'(AbcDigest[i]));
  endtask

  initial begin
    // Row 0 is the "abc" block; W16/W17 below are derived by hand from sigma0/sigma1.
    vecs[0] = '{d: 8'd3,   m0: 32'h61626380, m1: 32'h0, m15: 32'h18,
                exp_w16: 32'h61626380, exp_w17: 32'h000f0000};
    vecs[1] = '{d: 8'd0,   m0: 32'h0, m1: 32'h1, m15: 32'h0,
                exp_w16: 32'h02004000, exp_w17: 32'h00000001};
    vecs[2] = '{d: 8'd1,   m0: 32'h80000000, m1: 32'h0, m15: 32'h400,
                exp_w16: 32'h80000000, exp_w17: 32'h02800001};
    vecs[3] = '{d: 8'd255, m0: 32'hffffffff, m1: 32'h1, m15: 32'h0,
                exp_w16: 32'h02003fff, exp_w17: 32'h00000001};
    vecs[4] = '{d: 8'd5,   m0: 32'h0, m1: 32'h0, m15: 32'h0,
                exp_w16: 32'h0, exp_w17: 32'h0};

    rst = 1'b1; run = 1'b0; in0 = 32'h0; configDelay = 8'd0;
    #2;
    check("reset_outputs", {31'd0, done, out0, out1}, {31'd0, 1'b1, 64'd0});
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      load_msg(vecs[v]);
      run_schedule(vecs[v].d, 64);
      check($sformatf("vec%0d_w16", v), 96'(cap_w[16]), 96'(vecs[v].exp_w16));
      check($sformatf("vec%0d_w17", v), 96'(cap_w[17]), 96'(vecs[v].exp_w17));
      if (v == 0) begin
        check("k_round0", 96'(cap_k[0]), 96'h428a2f98);
        check("k_round63", 96'(cap_k[63]), 96'hc67178f2);
        check_digest();
      end
    end

    // Restart at round 40, then a fresh schedule for a different message.
    load_msg(vecs[0]);
    run_schedule(8'd2, 40);
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    run_schedule(8'd4, 64);

    // Asynchronous reset while round 30 is being presented.
    load_msg(vecs[2]);
    run_schedule(8'd2, 30);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_run", {31'd0, done, out0, out1}, {31'd0, 1'b1, 64'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in0 = $urandom;
      @(negedge clk);
      check($sformatf("idle_after_rst_%0d", c), {31'd0, done, out0, out1},
            {31'd0, 1'b1, 64'd0});
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
